// File: rtl/layer_argmax_if.sv
// Handshake bundle for layer_argmax: upstream FIFO read port plus downstream
// result port. The slave modport is the argmax block; the master modport is its environment.
interface layer_argmax_if #(
  parameter int WORD_SIZE   = 8,
  parameter int INDEX_WIDTH = 2
);
  logic [WORD_SIZE-1:0]   data_i;
  logic                   empty_i;
  logic                   ren_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [INDEX_WIDTH-1:0] index_o;
  logic [WORD_SIZE-1:0]   max_o;

  modport slave (
    input  data_i, empty_i, ready_i,
    output ren_o, valid_o, index_o, max_o
  );

  modport master (
    output data_i, empty_i, ready_i,
    input  ren_o, valid_o, index_o, max_o
  );
endinterface

// File: rtl/layer_argmax.sv
// Streaming argmax over one layer vector of signed activations: collects
// LAYER_HEIGHT words from a FIFO, then holds the winning index/value until taken.
module layer_argmax #(
  parameter int WORD_SIZE    = 8,
  parameter int LAYER_HEIGHT = 4,
  parameter int INDEX_WIDTH  = $clog2(LAYER_HEIGHT)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  layer_argmax_if.slave      bus
);

  typedef enum logic {COLLECT, DONE} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(LAYER_HEIGHT - 1);

  state_t                 state;
  logic [INDEX_WIDTH-1:0] count;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [WORD_SIZE-1:0]   max_q;
  logic                   accept;
  logic                   take_word;

  assign accept    = (state == COLLECT) && !bus.empty_i;
  // First word of a vector always wins; later ones only on a strict signed
  // improvement, so ties stay with the earliest arrival.
  assign take_word = (count == '0) || ($signed(bus.data_i) > $signed(max_q));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= COLLECT;
      count   <= '0;
      index_q <= '0;
      max_q   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (take_word) begin
              max_q   <= bus.data_i;
              index_q <= count;
            end
            if (count == LAST_INDEX) begin
              state <= DONE;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            state <= COLLECT;
            count <= '0;
          end
        end
        default: begin
          state <= COLLECT;
          count <= '0;
        end
      endcase
    end
  end

  assign bus.ren_o   = (state == COLLECT);
  assign bus.valid_o = (state == DONE);
  assign bus.index_o = index_q;
  assign bus.max_o   = max_q;

endmodule

// File: doc/layer_argmax.md
LAYER_ARGMAX -- requirements
Module: layer_argmax

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, meaning bit width of one signed two's-complement activation word.
REQ-002 SHALL have parameter LAYER_HEIGHT, default 4, meaning number of words per input vector (>=2).
REQ-003 SHALL have parameter INDEX_WIDTH, default $clog2(LAYER_HEIGHT), meaning width of the class index output.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port data_i  input  WORD_SIZE  upstream FIFO head word, valid whenever empty_i=0.
REQ-007 SHALL have port empty_i  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port ren_o  output  1  read enable to upstream FIFO.
REQ-009 SHALL have port valid_o  output  1  result valid to downstream.
REQ-010 SHALL have port ready_i  input  1  downstream ready.
REQ-011 SHALL have port index_o  output  INDEX_WIDTH  position (0-based, arrival order) of maximum word.
REQ-012 SHALL have port max_o  output  WORD_SIZE  value of maximum word.

Function
REQ-013 SHALL implement two states: COLLECT and DONE.
REQ-014 SHALL drive ren_o=1 in COLLECT and ren_o=0 in DONE, combinationally from state only.
REQ-015 SHALL accept a word on a rising edge only when ren_o=1 and empty_i=0; no accept when empty_i=1 (stall, no state change).
REQ-016 SHALL keep a word counter 0..LAYER_HEIGHT-1, incremented per accepted word, cleared on COLLECT entry.
REQ-017 SHALL, on accepting the word at count 0, load max register with data_i and index register with 0 unconditionally.
REQ-018 SHALL, on accepting a word at count k>0, load max/index with data_i/k only if data_i > max under signed comparison.
REQ-019 SHALL resolve ties in favour of the lower index (strict greater-than only).
REQ-020 SHALL, on accepting the word at count LAYER_HEIGHT-1, transition to DONE at the same edge, with max/index final.
REQ-021 SHALL drive valid_o=1 exactly while in DONE; latency 1 cycle from last-word accept edge to valid_o visible.
REQ-022 SHALL hold index_o and max_o stable while valid_o=1 and ready_i=0.
REQ-023 SHALL, on an edge with valid_o=1 and ready_i=1, return to COLLECT with counter 0; no word is accepted on that edge.
REQ-024 SHALL drive index_o/max_o from registers; values outside DONE are don't-care for the consumer.
REQ-025 SHALL sustain at most one vector per LAYER_HEIGHT+1 cycles (no overlap of DONE and COLLECT).

Reset
REQ-026 SHALL, while reset_i=0, asynchronously force state=COLLECT, counter=0, max=0, index=0, valid_o=0.
REQ-027 SHALL drive ren_o=1 immediately after reset deassertion (COLLECT).
REQ-028 SHALL discard any partial vector on reset mid-COLLECT and any pending result on reset in DONE; next vector starts at index 0.

Verification (WORD_SIZE=8, LAYER_HEIGHT=4, words listed in arrival order)
REQ-029 SHALL cover: FIFO words 0x36,0x14,0x10,0xaf back-to-back, ready_i=1 -> valid_o one cycle after 4th accept, index_o=0, max_o=0x36 (0xaf is -81, not max).
REQ-030 SHALL cover: words 0x11,0xa1,0x01,0x11 (tie) -> index_o=0, max_o=0x11.
REQ-031 SHALL cover: all negative 0x80,0xff,0x90,0xfe -> index_o=1, max_o=0xff.
REQ-032 SHALL cover: empty_i=1 for 3 cycles between words 2 and 3 of 0x01,0x02,0x7f,0x03 -> no accepts during gap, index_o=2, max_o=0x7f.
REQ-033 SHALL cover: ready_i=0 for 5 cycles in DONE -> valid_o, index_o, max_o held, ren_o=0, FIFO not read; ready_i=1 -> COLLECT next edge, next vector 0x05,0x09,0x02,0x01 gives index_o=1.
REQ-034 SHALL cover: reset_i pulsed low after 2 words accepted -> valid_o=0 and ren_o=1 immediately after release; following 4 words 0x00,0x00,0x40,0x00 give index_o=2, max_o=0x40.
